te_stage2_rx_seq: RTL and testbench
===================================

// Module: te_stage2_rx_seq
// PURPOSE
//  Receiving-end (Stage2) sequencer of the timing-engine interface. Consumes pllSettled/tArstFs driven by
//  the Stage1 producer in the less-on power domain and generates radioEnable/radioRxEn.
//  Stage1 inputs are clamped when isolateM1=1; the block re-qualifies the PLL after every isolation episode.
//  Sits in the always-on side (PD_M2), between Stage1 and the radio front-end.
// PARAMETERS
//  SETTLE_CYCLES   4     consecutive qualified pllSettled cycles required before ramp (>=1)
//  RAMP_CYCLES     8     cycles spent in RAMP before RX is enabled (>=1)
//  TIMEOUT_CYCLES  256   WAIT_PLL watchdog length; used only with TE_PLL_TIMEOUT_EN
// PORTS
//  ck          in   1  clock
//  arst        in   1  asynchronous reset, active-low
//  isolateM1   in   1  1 = Stage1 powered down/isolated, its outputs invalid
//  enableReq   in   1  local (Stage2) request to run the radio; level
//  pllSettled  in   1  from Stage1: PLL lock indication
//  tArstFs     in   1  from Stage1: fast synchronous shutdown request
//  radioEnable out  1  radio supply/PLL enable
//  radioRxEn   out  1  receiver enable
//  pllTimeout  out  1  1-cycle pulse: WAIT_PLL watchdog expired (tied 0 without macro)
// BEHAVIOUR
//  - Reset (arst=0): state IDLE, radioEnable=0, radioRxEn=0, pllTimeout=0, all counters 0, capture regs 0.
//  - Capture stage (1 cycle): pllQ<=pllSettled&~isolateM1; fsQ<=tArstFs&~isolateM1; isoQ<=isolateM1.
//    FSM uses only pllQ/fsQ/isoQ and enableReq (enableReq is local, not captured).
//  - Outputs are registered, decoded from next state: they change on the same edge as the state.
//    Input change -> output change = 2 edges for Stage1 signals, 1 edge for enableReq.
//  - States: IDLE, WAIT_PLL, RAMP, RX_ON, ISO_HOLD.
//    Outputs: IDLE 0/0; WAIT_PLL 1/0; RAMP 1/0; RX_ON 1/1; ISO_HOLD 1/0 (radioEnable/radioRxEn).
//  - Transition priority per edge: fsQ > !enableReq > isoQ > normal.
//    fsQ=1 in any state -> IDLE. !enableReq in any non-IDLE state -> IDLE.
//    isoQ=1 in WAIT_PLL/RAMP/RX_ON -> ISO_HOLD.
//  - IDLE: enableReq=1 -> WAIT_PLL, clear settleCnt.
//  - WAIT_PLL: pllQ=1 -> settleCnt++; pllQ=0 -> settleCnt<=0.
//    Exit to RAMP when pllQ=1 and settleCnt==SETTLE_CYCLES-1; load rampCnt<=RAMP_CYCLES-1.
//  - RAMP: pllQ=0 -> WAIT_PLL (settleCnt<=0). rampCnt==0 -> RX_ON. Otherwise rampCnt--.
//    RAMP lasts exactly RAMP_CYCLES cycles.
//  - RX_ON: pllQ=0 -> WAIT_PLL (settleCnt<=0).
//  - ISO_HOLD: isoQ=0 -> WAIT_PLL (settleCnt<=0); PLL always re-qualified.
//  - Counters never wrap: settleCnt saturates at SETTLE_CYCLES-1; widths $clog2(param+1).
//  - Reset mid-operation: async, outputs 0 immediately, no completion of ramp.
// CONFIGURATION
//  TE_PLL_TIMEOUT_EN defined: wdCnt counts cycles in WAIT_PLL (cleared on entry).
//    wdCnt==TIMEOUT_CYCLES-1 without exit -> IDLE, pllTimeout=1 for exactly one cycle.
//    enableReq must drop and re-assert before WAIT_PLL is re-entered.
//    Lower priority than fsQ/!enableReq/isoQ; ISO_HOLD time is not counted.
//  TE_PLL_TIMEOUT_EN undefined: no wdCnt, WAIT_PLL waits indefinitely, pllTimeout tied 0.
// STRUCTURE
//  Package timing_engine_pkg: te_state_e enum (IDLE, WAIT_PLL, RAMP, RX_ON, ISO_HOLD),
//  default SETTLE/RAMP/TIMEOUT constants.
//  Sub-module te_iso_capture: isolation clamp + capture flops (pllQ, fsQ, isoQ); reusable for other Stage2 consumers.
// TESTING (SETTLE_CYCLES=4, RAMP_CYCLES=8)
//  1 Bring-up: release reset, pllSettled=1, then enableReq=1 at edge E.
//    -> radioEnable=1 at E; radioRxEn=1 at E+12; pllTimeout stays 0.
//  2 Isolation in RX_ON: isolateM1=1 for 5 cycles from edge F.
//    -> radioRxEn=0 at F+1, radioEnable stays 1.
//    -> isolateM1 released at F+5: ISO_HOLD exits at F+6, radioRxEn=1 again at F+18.
//  3 tArstFs 1-cycle pulse during RAMP at edge G.
//    -> both outputs 0 at G+1; same pulse with isolateM1=1 -> ignored, RX_ON reached normally.
//  4 pllSettled drops for 2 cycles after 3 qualified cycles in WAIT_PLL.
//    -> settle restarts, RAMP entered only after 4 further consecutive qualified cycles.
//  5 Simultaneous: enableReq=0 and isolateM1=1 in RX_ON -> IDLE (not ISO_HOLD), outputs 0.
//    arst=0 mid-RAMP -> outputs 0 without clock edge.
//  6 With TE_PLL_TIMEOUT_EN, TIMEOUT_CYCLES=16, pllSettled=0.
//    -> 16 cycles after WAIT_PLL entry: IDLE, pllTimeout=1 for 1 cycle, radioEnable=0.

Source files
------------

// File: rtl/timing_engine_pkg.sv
// Shared types and default timing constants for the timing-engine Stage2 blocks.
package timing_engine_pkg;

  // Sequencer states; encoding is free, outputs are decoded explicitly.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PLL = 3'd1,
    RAMP     = 3'd2,
    RX_ON    = 3'd3,
    ISO_HOLD = 3'd4
  } te_state_e;

  localparam int TE_SETTLE_CYCLES_DEF  = 4;
  localparam int TE_RAMP_CYCLES_DEF    = 8;
  localparam int TE_TIMEOUT_CYCLES_DEF = 256;

  // True for states in which a Stage1 isolation episode forces ISO_HOLD.
  function automatic logic te_iso_sensitive(input te_state_e s);
    return (s == WAIT_PLL) || (s == RAMP) || (s == RX_ON);
  endfunction

endpackage

// File: rtl/te_iso_capture.sv
// Isolation clamp and capture flops for Stage1 signals entering a Stage2 consumer.
// While isolated, Stage1 outputs are forced to 0 before they are captured.
module te_iso_capture (
  input  logic ck,
  input  logic arst,
  input  logic iso_in,
  input  logic pll_in,
  input  logic fs_in,
  output logic pll_q,
  output logic fs_q,
  output logic iso_q
);

  logic pll_d;
  logic fs_d;
  logic iso_d;

  // Clamp Stage1 values with the isolation indication.
  always_comb begin
    pll_d = pll_in & ~iso_in;
    fs_d  = fs_in & ~iso_in;
    iso_d = iso_in;
  end

  // One-cycle capture stage; all Stage1-derived state starts cleared.
  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      pll_q <= 1'b0;
      fs_q  <= 1'b0;
      iso_q <= 1'b0;
    end else begin
      pll_q <= pll_d;
      fs_q  <= fs_d;
      iso_q <= iso_d;
    end
  end

endmodule

// File: rtl/te_stage2_rx_seq.sv
// Stage2 receive sequencer: qualifies the Stage1 PLL and sequences radioEnable/radioRxEn.
// Optional PLL watchdog is compiled in with `define TE_PLL_TIMEOUT_EN.
module te_stage2_rx_seq
  import timing_engine_pkg::*;
#(
  parameter int SETTLE_CYCLES  = TE_SETTLE_CYCLES_DEF,
  parameter int RAMP_CYCLES    = TE_RAMP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TE_TIMEOUT_CYCLES_DEF
) (
  input  logic ck,
  input  logic arst,
  input  logic isolateM1,
  input  logic enableReq,
  input  logic pllSettled,
  input  logic tArstFs,
  output logic radioEnable,
  output logic radioRxEn,
  output logic pllTimeout
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int RAMP_W   = $clog2(RAMP_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST   = RAMP_W'(RAMP_CYCLES - 1);

  // Reject degenerate timing at elaboration.
  if (SETTLE_CYCLES < 1 || RAMP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("te_stage2_rx_seq: SETTLE/RAMP/TIMEOUT_CYCLES must be >= 1");
  end

  logic pll_q;
  logic fs_q;
  logic iso_q;

  te_iso_capture u_capture (
    .ck     (ck),
    .arst   (arst),
    .iso_in (isolateM1),
    .pll_in (pllSettled),
    .fs_in  (tArstFs),
    .pll_q  (pll_q),
    .fs_q   (fs_q),
    .iso_q  (iso_q)
  );

  te_state_e             state_q, state_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [RAMP_W-1:0]     ramp_cnt_q, ramp_cnt_d;
  logic                  radio_en_q, radio_en_d;
  logic                  radio_rx_q, radio_rx_d;
  logic                  start_ok;

`ifdef TE_PLL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_block_q, wd_block_d;
  logic            pll_timeout_q, pll_timeout_d;

  // After a timeout, the request must be withdrawn before a new attempt.
  assign start_ok   = ~wd_block_q;
  assign pllTimeout = pll_timeout_q;

  // Watchdog state: count, re-arm block and the one-cycle timeout pulse.
  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      wd_cnt_q      <= '0;
      wd_block_q    <= 1'b0;
      pll_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      wd_block_q    <= wd_block_d;
      pll_timeout_q <= pll_timeout_d;
    end
  end
`else
  assign start_ok   = 1'b1;
  assign pllTimeout = 1'b0;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      ramp_cnt_q   <= '0;
      radio_en_q   <= 1'b0;
      radio_rx_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      ramp_cnt_q   <= ramp_cnt_d;
      radio_en_q   <= radio_en_d;
      radio_rx_q   <= radio_rx_d;
    end
  end

  // Next state: fast shutdown, then request withdrawal, then isolation, then normal flow.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    ramp_cnt_d   = ramp_cnt_q;
`ifdef TE_PLL_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    wd_block_d    = wd_block_q & enableReq;
    pll_timeout_d = 1'b0;
`endif
    if (fs_q) begin
      state_d = IDLE;
    end else if (!enableReq) begin
      state_d = IDLE;
    end else if (iso_q && te_iso_sensitive(state_q)) begin
      state_d = ISO_HOLD;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d      = WAIT_PLL;
            settle_cnt_d = '0;
          end
        end
        WAIT_PLL: begin
          if (pll_q) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d    = RAMP;
              ramp_cnt_d = RAMP_LAST;
            end else begin
              settle_cnt_d = settle_cnt_q + 1'b1;
            end
          end else begin
            settle_cnt_d = '0;
          end
`ifdef TE_PLL_TIMEOUT_EN
          // Watchdog only fires when no other exit was taken this cycle.
          if (state_d == WAIT_PLL) begin
            if (wd_cnt_q == WD_LAST) begin
              state_d       = IDLE;
              pll_timeout_d = 1'b1;
              wd_block_d    = 1'b1;
            end else begin
              wd_cnt_d = wd_cnt_q + 1'b1;
            end
          end
`endif
        end
        RAMP: begin
          if (!pll_q) begin
            state_d      = WAIT_PLL;
            settle_cnt_d = '0;
          end else if (ramp_cnt_q == '0) begin
            state_d = RX_ON;
          end else begin
            ramp_cnt_d = ramp_cnt_q - 1'b1;
          end
        end
        RX_ON: begin
          if (!pll_q) begin
            state_d      = WAIT_PLL;
            settle_cnt_d = '0;
          end
        end
        ISO_HOLD: begin
          // Lock state from before isolation is not trusted: always re-qualify.
          if (!iso_q) begin
            state_d      = WAIT_PLL;
            settle_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef TE_PLL_TIMEOUT_EN
    // Every fresh entry into WAIT_PLL starts a new watchdog period.
    if (state_d == WAIT_PLL && state_q != WAIT_PLL) begin
      wd_cnt_d = '0;
    end
`endif
  end

  // Outputs decoded from the next state so they move on the same edge as the state.
  always_comb begin
    radio_en_d = (state_d != IDLE);
    radio_rx_d = (state_d == RX_ON);
  end

  assign radioEnable = radio_en_q;
  assign radioRxEn   = radio_rx_q;

endmodule

// File: tb/tb_te_stage2_rx_seq.sv
// Self-checking bench for te_stage2_rx_seq (SETTLE=4, RAMP=8, TIMEOUT=16).
// Expected outputs are queued with their target edge and compared on the falling edge.
module tb_te_stage2_rx_seq;

  localparam int SETTLE  = 4;
  localparam int RAMPC   = 8;
  localparam int TIMEOUT = 16;

  logic ck = 1'b0;
  logic arst = 1'b0;
  logic isolateM1 = 1'b0;
  logic enableReq = 1'b0;
  logic pllSettled = 1'b0;
  logic tArstFs = 1'b0;
  logic radioEnable;
  logic radioRxEn;
  logic pllTimeout;

  te_stage2_rx_seq #(
    .SETTLE_CYCLES  (SETTLE),
    .RAMP_CYCLES    (RAMPC),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .ck          (ck),
    .arst        (arst),
    .isolateM1   (isolateM1),
    .enableReq   (enableReq),
    .pllSettled  (pllSettled),
    .tArstFs     (tArstFs),
    .radioEnable (radioEnable),
    .radioRxEn   (radioRxEn),
    .pllTimeout  (pllTimeout)
  );

  always #5 ck = ~ck;

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    int    at;
    logic  en;
    logic  rx;
    logic  to;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int at, input logic en, input logic rx, input logic to,
                          input string tag);
    exp_t e;
    e.at = at; e.en = en; e.rx = rx; e.to = to; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  // Scoreboard monitor: pop every expectation due at this edge.
  always @(negedge ck) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      e = sb_q.pop_front();
      if (e.at < cyc) begin
        check_val({e.tag, "_missed"}, cyc, e.at);
      end else begin
        $display("cyc=%0d %s en=%0b rx=%0b to=%0b", cyc, e.tag, radioEnable, radioRxEn, pllTimeout);
        check_val({e.tag, "_en"}, radioEnable, e.en);
        check_val({e.tag, "_rx"}, radioRxEn, e.rx);
        check_val({e.tag, "_to"}, pllTimeout, e.to);
      end
    end
  end

  initial begin
    int e1, f, g, n;

    // Reset state
    #2;
    check_val("rst_en", radioEnable, 0);
    check_val("rst_rx", radioRxEn, 0);
    check_val("rst_to", pllTimeout, 0);
    tick(2);
    arst = 1'b1;
    pllSettled = 1'b1;
    tick(3);

    // 1: bring-up
    enableReq = 1'b1;
    e1 = cyc + 1;
    push_exp(e1,      1, 0, 0, "t1_enter");
    push_exp(e1 + 4,  1, 0, 0, "t1_ramp_start");
    push_exp(e1 + 11, 1, 0, 0, "t1_ramp_end");
    push_exp(e1 + 12, 1, 1, 0, "t1_rx_on");
    tick(14);

    // 2: isolation for 5 cycles in RX_ON
    isolateM1 = 1'b1;
    f = cyc + 1;
    push_exp(f,      1, 1, 0, "t2_pre");
    push_exp(f + 1,  1, 0, 0, "t2_iso");
    push_exp(f + 5,  1, 0, 0, "t2_hold");
    push_exp(f + 6,  1, 0, 0, "t2_requal");
    push_exp(f + 17, 1, 0, 0, "t2_ramp_end");
    push_exp(f + 18, 1, 1, 0, "t2_rx_back");
    tick(5);
    isolateM1 = 1'b0;
    tick(16);

    // 3a: tArstFs pulse during RAMP
    enableReq = 1'b0;
    push_exp(cyc + 1, 0, 0, 0, "t3_idle");
    tick(1);
    enableReq = 1'b1;
    push_exp(cyc + 1, 1, 0, 0, "t3_enter");
    tick(6);
    tArstFs = 1'b1;
    g = cyc + 1;
    push_exp(g,      1, 0, 0, "t3_ramp");
    push_exp(g + 1,  0, 0, 0, "t3_fs_off");
    push_exp(g + 2,  1, 0, 0, "t3_restart");
    push_exp(g + 13, 1, 0, 0, "t3_ramp_end");
    push_exp(g + 14, 1, 1, 0, "t3_rx");
    tick(1);
    tArstFs = 1'b0;
    tick(15);

    // 3b: same pulse while isolated is ignored; only an isolation episode follows
    enableReq = 1'b0;
    push_exp(cyc + 1, 0, 0, 0, "t3b_idle");
    tick(1);
    enableReq = 1'b1;
    push_exp(cyc + 1, 1, 0, 0, "t3b_enter");
    tick(6);
    tArstFs = 1'b1;
    isolateM1 = 1'b1;
    g = cyc + 1;
    push_exp(g,      1, 0, 0, "t3b_ramp");
    push_exp(g + 1,  1, 0, 0, "t3b_fs_ignored");
    push_exp(g + 2,  1, 0, 0, "t3b_requal");
    push_exp(g + 13, 1, 0, 0, "t3b_ramp_end");
    push_exp(g + 14, 1, 1, 0, "t3b_rx");
    tick(1);
    tArstFs = 1'b0;
    isolateM1 = 1'b0;
    tick(15);

    // 4: PLL drops for 2 cycles after 3 qualified cycles
    enableReq = 1'b0;
    push_exp(cyc + 1, 0, 0, 0, "t4_idle");
    tick(1);
    enableReq = 1'b1;
    e1 = cyc + 1;
    push_exp(e1,      1, 0, 0, "t4_enter");
    push_exp(e1 + 16, 1, 0, 0, "t4_late_ramp");
    push_exp(e1 + 17, 1, 1, 0, "t4_rx");
    tick(3);
    pllSettled = 1'b0;
    tick(2);
    pllSettled = 1'b1;
    tick(15);

    // 5a: request withdrawal wins over isolation
    isolateM1 = 1'b1;
    n = cyc;
    push_exp(n + 1, 1, 1, 0, "t5_pre");
    tick(1);
    enableReq = 1'b0;
    push_exp(n + 2, 0, 0, 0, "t5_idle_not_hold");
    push_exp(n + 3, 0, 0, 0, "t5_idle_stay");
    tick(1);
    isolateM1 = 1'b0;
    tick(3);

    // 5b: asynchronous reset mid-RAMP
    enableReq = 1'b1;
    push_exp(cyc + 1, 1, 0, 0, "t5b_enter");
    tick(7);
    check_val("t5b_in_ramp_en", radioEnable, 1);
    #2;
    arst = 1'b0;
    #1;
    check_val("t5b_arst_en", radioEnable, 0);
    check_val("t5b_arst_rx", radioRxEn, 0);
    enableReq = 1'b0;
    tick(1);
    check_val("t5b_held_en", radioEnable, 0);
    arst = 1'b1;
    tick(2);

`ifdef TE_PLL_TIMEOUT_EN
    // 6: watchdog with no PLL lock
    pllSettled = 1'b0;
    tick(2);
    enableReq = 1'b1;
    e1 = cyc + 1;
    push_exp(e1,      1, 0, 0, "t6_enter");
    push_exp(e1 + 15, 1, 0, 0, "t6_last_wait");
    push_exp(e1 + 16, 0, 0, 1, "t6_timeout");
    push_exp(e1 + 17, 0, 0, 0, "t6_pulse_end");
    push_exp(e1 + 20, 0, 0, 0, "t6_blocked");
    tick(21);
    enableReq = 1'b0;
    push_exp(cyc + 1, 0, 0, 0, "t6_drop");
    tick(1);
    enableReq = 1'b1;
    push_exp(cyc + 1, 1, 0, 0, "t6_reenter");
    tick(2);
    enableReq = 1'b0;
    tick(2);
`endif

    tick(3);
    check_val("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
